ssb_symbol_scheduler: RTL



---
 rtl/ssb_pkg.sv | 19 +
 rtl/ssb_sym_counter.sv | 43 ++++
 rtl/ssb_symbol_scheduler.sv | 127 ++++++++++++
 3 files changed

// File: rtl/ssb_pkg.sv
// Shared types and constants for the SS-block symbol scheduler.
// State encoding, symbol index names and the 256-point grid defaults.
package ssb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PRE_WIN  = 2'd1,
        WIN      = 2'd2,
        POST_WIN = 2'd3
    } ssb_state_e;

    localparam logic [1:0] SYM_PBCH1 = 2'd1;
    localparam logic [1:0] SYM_SSS   = 2'd2;
    localparam logic [1:0] SYM_PBCH2 = 2'd3;

    localparam int DEF_FFT_LEN = 256;
    localparam int DEF_CP_LEN  = 18;

endpackage

// File: rtl/ssb_sym_counter.sv
// Valid-gated sample/symbol position counter with wrap and terminal flags.
// Latency: counts update on the clock after an advancing sample; start has priority.
// Backpressure: none; stalls simply by holding adv_i low.
module ssb_sym_counter #(
    parameter int SYM_LEN  = 274,
    parameter int NUM_SYMS = 3,
    parameter int SCW      = $clog2(SYM_LEN),
    parameter int SYW      = 2
) (
    input  logic           clk_i,
    input  logic           reset_ni,
    input  logic           start_i,
    input  logic           adv_i,
    output logic [SCW-1:0] sample_cnt_o,
    output logic [SYW-1:0] sym_cnt_o,
    output logic           last_sample_o,
    output logic           last_sym_o
);

    localparam logic [SCW-1:0] SAMPLE_LAST = SCW'(SYM_LEN - 1);

    assign last_sample_o = (sample_cnt_o == SAMPLE_LAST);
    assign last_sym_o    = (sym_cnt_o == SYW'(NUM_SYMS));

    // Wrapping out of the final symbol returns the symbol index to 0 so idle reads 0.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            sample_cnt_o <= '0;
            sym_cnt_o    <= '0;
        end else if (start_i) begin
            sample_cnt_o <= '0;
            sym_cnt_o    <= SYW'(1);
        end else if (adv_i) begin
            if (last_sample_o) begin
                sample_cnt_o <= '0;
                sym_cnt_o    <= last_sym_o ? '0 : sym_cnt_o + 1'b1;
            end else begin
                sample_cnt_o <= sample_cnt_o + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ssb_symbol_scheduler.sv
// Gates FFT windows for the SS-block symbols after a PSS peak; SSB_SCHED_RETRIGGER_EN allows busy restarts.
// Latency: 1 cycle input sample to m_axis_out; strobes and tlast aligned with tvalid.
// Backpressure: none; input tvalid gaps stall all counting, the FFT side is always ready.
module ssb_symbol_scheduler import ssb_pkg::*; #(
    parameter int IN_DW      = 32,
    parameter int FFT_LEN    = DEF_FFT_LEN,
    parameter int CP_LEN     = DEF_CP_LEN,
    parameter int CP_ADVANCE = 9,
    parameter int NUM_SYMS   = 3
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             peak_detected_i,
    input  logic [IN_DW-1:0] s_axis_in_tdata,
    input  logic             s_axis_in_tvalid,
    output logic [IN_DW-1:0] m_axis_out_tdata,
    output logic             m_axis_out_tvalid,
    output logic             m_axis_out_tlast,
    output logic [1:0]       sym_idx_o,
    output logic             PBCH_start_o,
    output logic             SSS_start_o,
    output logic             busy_o
`ifdef SSB_SCHED_RETRIGGER_EN
    ,
    output logic [15:0]      retrigger_cnt_o
`endif
);

    localparam int SYM_LEN = CP_LEN + FFT_LEN;
    localparam int SCW     = $clog2(SYM_LEN);
    localparam int PRE_END = CP_LEN - CP_ADVANCE;

    localparam logic [SCW-1:0] PRE_LAST  = SCW'((PRE_END > 0) ? PRE_END - 1 : 0);
    localparam logic [SCW-1:0] WIN_FIRST = SCW'(PRE_END);
    localparam logic [SCW-1:0] WIN_LAST  = SCW'(PRE_END + FFT_LEN - 1);
    // With the window pushed fully into the CP there is no discard phase at symbol start.
    localparam ssb_state_e SYM_ENTRY = (PRE_END == 0) ? WIN : PRE_WIN;

    ssb_state_e     state_q, state_d;
    logic [SCW-1:0] sample_cnt;
    logic [1:0]     sym_cnt;
    logic           last_sample, last_sym;
    logic           busy, fwd, final_smp, accept_peak, retrig, cnt_start;
    logic           win_first, win_end;

    assign final_smp   = busy && s_axis_in_tvalid && last_sample && last_sym;
    assign accept_peak = (state_q == IDLE) && peak_detected_i;
`ifdef SSB_SCHED_RETRIGGER_EN
    assign retrig      = busy && peak_detected_i && !final_smp;
`else
    assign retrig      = 1'b0;
`endif
    assign cnt_start   = accept_peak || retrig;

    ssb_sym_counter #(
        .SYM_LEN  (SYM_LEN),
        .NUM_SYMS (NUM_SYMS),
        .SCW      (SCW),
        .SYW      (2)
    ) u_cnt (
        .clk_i         (clk_i),
        .reset_ni      (reset_ni),
        .start_i       (cnt_start),
        .adv_i         (busy && s_axis_in_tvalid),
        .sample_cnt_o  (sample_cnt),
        .sym_cnt_o     (sym_cnt),
        .last_sample_o (last_sample),
        .last_sym_o    (last_sym)
    );

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) state_q <= IDLE;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (peak_detected_i) state_d = SYM_ENTRY;
            PRE_WIN:  if (s_axis_in_tvalid && sample_cnt == PRE_LAST) state_d = WIN;
            WIN: begin
                if (s_axis_in_tvalid && sample_cnt == WIN_LAST) begin
                    if (CP_ADVANCE > 0) state_d = POST_WIN;
                    else                state_d = last_sym ? IDLE : SYM_ENTRY;
                end
            end
            POST_WIN: if (s_axis_in_tvalid && last_sample) state_d = last_sym ? IDLE : SYM_ENTRY;
            default:  state_d = IDLE;
        endcase
        if (retrig) state_d = SYM_ENTRY;
    end

    always_comb begin
        busy      = (state_q != IDLE);
        fwd       = (state_q == WIN) && s_axis_in_tvalid;
        win_first = (sample_cnt == WIN_FIRST);
        win_end   = (sample_cnt == WIN_LAST);
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            m_axis_out_tdata  <= '0;
            m_axis_out_tvalid <= 1'b0;
            m_axis_out_tlast  <= 1'b0;
            PBCH_start_o      <= 1'b0;
            SSS_start_o       <= 1'b0;
        end else begin
            m_axis_out_tvalid <= fwd;
            if (fwd) m_axis_out_tdata <= s_axis_in_tdata;
            // A restart inside a window closes the current FFT frame on this sample.
            m_axis_out_tlast  <= fwd && (win_end || retrig);
            PBCH_start_o      <= fwd && win_first && (sym_cnt == SYM_PBCH1 || sym_cnt == SYM_PBCH2);
            SSS_start_o       <= fwd && win_first && (sym_cnt == SYM_SSS);
        end
    end

`ifdef SSB_SCHED_RETRIGGER_EN
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni)                             retrigger_cnt_o <= '0;
        else if (retrig && retrigger_cnt_o != '1)  retrigger_cnt_o <= retrigger_cnt_o + 1'b1;
    end
`endif

    assign sym_idx_o = sym_cnt;
    assign busy_o    = busy;

endmodule
